// File: rtl/mw_writeback_stage_if.sv
// Interface bundling the MW stage's execute-stage inputs, the data-memory load
// response and the register-file / forwarding outputs.
//   master : upstream side (drives X-stage fields and memory response, reads outputs)
//   slave  : the MW stage itself
interface mw_writeback_stage_if;
    logic        valid_x;
    logic [4:0]  rd_x;
    logic        rwe_x;
    logic [1:0]  wb_sel_x;
    logic [2:0]  funct3_x;
    logic [31:0] alu_x;
    logic [31:0] pc_x;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic [4:0]  rd_mw;
    logic        rwe_mw;
    logic [31:0] wb_data_mw;
    logic        stall_mw;

    modport master (
        output valid_x, rd_x, rwe_x, wb_sel_x, funct3_x, alu_x, pc_x,
        output dmem_resp_valid, dmem_resp_data,
        input  rd_mw, rwe_mw, wb_data_mw, stall_mw
    );

    modport slave (
        input  valid_x, rd_x, rwe_x, wb_sel_x, funct3_x, alu_x, pc_x,
        input  dmem_resp_valid, dmem_resp_data,
        output rd_mw, rwe_mw, wb_data_mw, stall_mw
    );
endinterface

// File: rtl/mw_writeback_stage.sv
// Memory/writeback stage of the three-stage RV32I pipeline. Registers the
// instruction leaving execute, waits for the load response, formats load data
// and selects the writeback value for the register file and forwarding path.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : X-stage fields, dmem response in; rd/rwe/wb_data/stall out
module mw_writeback_stage (
    input logic              clk,
    input logic              rst_n,
    mw_writeback_stage_if.slave bus
);

    typedef enum logic {StIdle, StLoad} state_e;

    state_e      state_q, state_d;
    logic        valid_q;
    logic [4:0]  rd_q;
    logic        rwe_q;
    logic [1:0]  wb_sel_q;
    logic [2:0]  funct3_q;
    logic [31:0] alu_q;
    logic [31:0] pc_q;

    logic        stall;
    logic        rwe_out;
    logic        we;
    logic        next_is_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data;

    assign we           = valid_q & rwe_q & (rd_q != 5'd0);
    assign next_is_load = bus.valid_x & (bus.wb_sel_x == 2'd1);

    // Stall depends only on state and the memory response, never on X inputs.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        rwe_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                rwe_out = we;
                state_d = next_is_load ? StLoad : StIdle;
            end
            StLoad: begin
                if (!bus.dmem_resp_valid) begin
                    stall = 1'b1;
                end else begin
                    rwe_out = we;
                    state_d = next_is_load ? StLoad : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            rd_q     <= 5'd0;
            rwe_q    <= 1'b0;
            wb_sel_q <= 2'd0;
            funct3_q <= 3'd0;
            alu_q    <= 32'd0;
            pc_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                valid_q  <= bus.valid_x;
                rd_q     <= bus.rd_x;
                rwe_q    <= bus.rwe_x;
                wb_sel_q <= bus.wb_sel_x;
                funct3_q <= bus.funct3_x;
                alu_q    <= bus.alu_x;
                pc_q     <= bus.pc_x;
            end
        end
    end

    // Load alignment: byte by alu[1:0], halfword by alu[1].
    always_comb begin
        ld_byte = 8'd0;
        unique case (alu_q[1:0])
            2'd0: ld_byte = bus.dmem_resp_data[7:0];
            2'd1: ld_byte = bus.dmem_resp_data[15:8];
            2'd2: ld_byte = bus.dmem_resp_data[23:16];
            2'd3: ld_byte = bus.dmem_resp_data[31:24];
            default: ld_byte = 8'd0;
        endcase
        ld_half = alu_q[1] ? bus.dmem_resp_data[31:16] : bus.dmem_resp_data[15:0];

        ld_data = bus.dmem_resp_data;
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.dmem_resp_data;
        endcase
    end

    always_comb begin
        wb_data = alu_q;
        case (wb_sel_q)
            2'd1:    wb_data = ld_data;
            2'd2:    wb_data = pc_q + 32'd4;
            default: wb_data = alu_q;
        endcase
    end

    assign bus.rd_mw      = rd_q;
    assign bus.rwe_mw     = rwe_out;
    assign bus.wb_data_mw = wb_data;
    assign bus.stall_mw   = stall;

endmodule

// File: doc/mw_writeback_stage.md
# mw_writeback_stage

Memory/writeback (MW) stage of the three-stage RV32I pipeline. Registers the instruction leaving the execute stage, waits for the data-memory load response, aligns and sign-extends load data, and selects the writeback value. Its outputs `rd_mw`, `rwe_mw` and `wb_data_mw` drive the register-file write port. The same outputs are the forwarding source consumed by the stage-2 operand selector. The block stalls upstream stages while a load response is outstanding.

## Interface
Parameters: none (XLEN fixed at 32).

Ports:
- `clk` in 1: rising-edge clock, the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `valid_x` in 1: the execute stage holds a real instruction; 0 means a bubble.
- `rd_x` in 5: destination register.
- `rwe_x` in 1: register write enable.
- `wb_sel_x` in 2: writeback source. 0 = ALU, 1 = load, 2 = PC+4, 3 = reserved (treated as ALU).
- `funct3_x` in 3: load width/sign (RV32I encoding).
- `alu_x` in 32: ALU result; this is the load address for loads.
- `pc_x` in 32: instruction PC.
- `dmem_resp_valid` in 1: load data valid this cycle.
- `dmem_resp_data` in 32: raw aligned word from data memory.
- `rd_mw` out 5: registered destination.
- `rwe_mw` out 1: write enable, qualified as described below.
- `wb_data_mw` out 32: writeback data, combinational from MW registers and the memory response.
- `stall_mw` out 1: freeze upstream stages and hold the X-stage inputs.

## Operation
- MW register fields: valid, rd, rwe, wb_sel, funct3, alu, pc. The fields capture the X-stage values on each rising edge where `stall_mw`=0.
- If `valid_x`=0, the captured valid bit is 0. All other fields are don't-care but must not produce a write.
- Effective write enable: `we` = valid & rwe & (rd != 0). A write to x0 is never issued.
- FSM, two states:
  - IDLE: the MW register holds a non-load or a bubble. `stall_mw`=0, `rwe_mw`=`we`.
  - LOAD: entered whenever a valid instruction with wb_sel=1 is captured, from either state.
    - While `dmem_resp_valid`=0: `stall_mw`=1 and `rwe_mw`=0.
    - On the cycle `dmem_resp_valid`=1: `stall_mw`=0 and `rwe_mw`=`we`. The next edge captures the next instruction. The next state is LOAD if that instruction is a valid load, otherwise IDLE.
- `dmem_resp_valid` is ignored in IDLE. A response is consumed only in LOAD, and only once.
- `wb_data_mw` source selection:
  - wb_sel 0 or 3: alu.
  - wb_sel 2: pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - wb_sel 1: load-formatted `dmem_resp_data`. Byte offset `off` = alu[1:0].
- Load formatting by funct3:
  - 000 LB: byte `off`, sign-extended.
  - 100 LBU: byte `off`, zero-extended.
  - 001 LH: halfword alu[1], sign-extended; alu[0] is ignored.
  - 101 LHU: halfword alu[1], zero-extended; alu[0] is ignored.
  - 010 LW: full word; offset is ignored.
  - Other codes: raw word.
- In LOAD while waiting, `wb_data_mw` is don't-care.
- For wb_sel=1 the output is gated by `dmem_resp_valid` through `rwe_mw`, so a forwarded value is only consumed when the data is real.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State IDLE; all MW fields 0.
  - `rd_mw`=0, `rwe_mw`=0, `wb_data_mw`=0, `stall_mw`=0.
  - Takes effect immediately, independent of `clk`.
- Reset mid-load: the pending load is dropped. No write is issued and `stall_mw` deasserts at once.
- Latency:
  - X-stage instruction to valid `rd_mw`/`rwe_mw`: 1 cycle.
  - `wb_data_mw` for ALU/PC+4: same cycle as the register output.
  - `wb_data_mw` for loads: same cycle as `dmem_resp_valid`, with zero added cycles.
- Stall behaviour: `stall_mw`=1 holds every MW field. The X-stage inputs are also held stable by upstream.
- `stall_mw` is combinational from the state and `dmem_resp_valid`. It has no path from any X-stage input.
- Back-to-back loads with a same-cycle response sustain 1 instruction per cycle with no stall.

## Test plan
- Reset:
  - Drive `rst_n`=0 mid-cycle with a load pending → all outputs 0 immediately.
  - Release, then present an ALU op rd=5, alu=0x12345678 → next cycle `rd_mw`=5, `rwe_mw`=1, `wb_data_mw`=0x12345678.
- x0 and bubble suppression:
  - rd=0, rwe=1, alu=0xFFFFFFFF → `rwe_mw`=0.
  - `valid_x`=0 → `rwe_mw`=0.
- PC+4 wrap: wb_sel=2 with pc=0x00000100 → 0x00000104; with pc=0xFFFFFFFC → 0x00000000.
- Load formatting with `dmem_resp_data`=0x80F17F02:
  - LB off0 → 0x00000002.
  - LB off3 → 0xFFFFFF80.
  - LBU off3 → 0x00000080.
  - LH alu[1]=1 → 0xFFFF80F1.
  - LHU alu[1:0]=3 → 0x000080F1.
  - LW → 0x80F17F02.
  - funct3=011 → 0x80F17F02.
- Delayed response:
  - Issue LW rd=7 with the response 3 cycles late → `stall_mw`=1 and `rwe_mw`=0 for 3 cycles.
  - On the response cycle, `rwe_mw`=1 with the data.
  - The following ALU op is captured on the next edge and is not lost.
  - A spurious `dmem_resp_valid` in IDLE is ignored.
- Back-to-back loads: three consecutive LW with same-cycle responses → no stall, three consecutive writes in order.
